// File: rtl/conv_pkg.sv
// Shared constants, layer-select codes and FSM states for the CONV host/memory block.
// Purpose: common definitions; latency: n/a; backpressure: n/a.
package conv_pkg;
    localparam int DW        = 20;
    localparam int IMG_AW    = 12;
    localparam int L1_AW     = 10;
    localparam int IMG_DEPTH = 4096;
    localparam int L1_DEPTH  = 1024;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DUMP0,
        ST_DUMP1,
        ST_DONE
    } state_t;
endpackage

// File: rtl/conv_host_mem_if.sv
// Bundle of the image-load stream, accelerator memory ports and result stream.
// Purpose: port grouping; latency: n/a; backpressure: valid/ready on s_* and m_*.
interface conv_host_mem_if;
    import conv_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic              ready;
    logic              busy;
    logic [IMG_AW-1:0] iaddr;
    logic [DW-1:0]     idata;
    logic              cwr;
    logic [IMG_AW-1:0] caddr_wr;
    logic [DW-1:0]     cdata_wr;
    logic              crd;
    logic [IMG_AW-1:0] caddr_rd;
    logic [DW-1:0]     cdata_rd;
    logic [2:0]        csel;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic              m_layer;
    logic              done;
    logic              err;

    // master is the environment (upstream, accelerator, downstream); slave is the host block.
    modport master (
        output s_valid, s_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
               crd, caddr_rd, csel, m_ready,
        input  s_ready, ready, idata, cdata_rd, m_valid, m_data, m_last,
               m_layer, done, err
    );

    modport slave (
        input  s_valid, s_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
               crd, caddr_rd, csel, m_ready,
        output s_ready, ready, idata, cdata_rd, m_valid, m_data, m_last,
               m_layer, done, err
    );
endinterface

// File: rtl/async_ram.sv
// Single write port RAM with an asynchronous read port; contents are never reset.
// Latency: write visible the cycle after the write edge, read is combinational; no backpressure.
module async_ram #(
    parameter int W     = 20,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/conv_host_mem.sv
// Host/memory side of CONV: loads the image, serves accelerator memory ports, streams L0 then L1 out.
// Latency: image/layer reads combinational, first result word 2 cycles after busy falls; m_* stalls on !m_ready.
// Optional ACCESS_CHECK_EN builds the sticky err access checker; otherwise err is tied low.
module conv_host_mem
    import conv_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    conv_host_mem_if.slave bus
);
    state_t            state, state_nxt;
    logic [IMG_AW-1:0] ld_cnt;
    logic [IMG_AW-1:0] dp_cnt;
    logic              busy_q;
    logic              dump_end;
    logic              adv;
    logic              issue;
    logic              in_dump;
    logic              img_we, l0_we, l1_we;
    logic [IMG_AW-1:0] l0_raddr;
    logic [L1_AW-1:0]  l1_raddr;
    logic [DW-1:0]     l0_rd, l1_rd;

    assign in_dump    = (state == ST_DUMP0) || (state == ST_DUMP1);
    assign adv        = !bus.m_valid || bus.m_ready;
    assign bus.s_ready = (state == ST_LOAD);
    assign bus.ready   = (state == ST_START);
    assign bus.done    = (state == ST_DONE);

    assign img_we = (state == ST_LOAD) && bus.s_valid;
    assign l0_we  = (state == ST_RUN) && bus.cwr && (bus.csel == CSEL_L0);
    assign l1_we  = (state == ST_RUN) && bus.cwr && (bus.csel == CSEL_L1);

    // The dump owns the layer read ports; the accelerator is idle by then.
    assign l0_raddr = in_dump ? dp_cnt : bus.caddr_rd;
    assign l1_raddr = in_dump ? dp_cnt[L1_AW-1:0] : bus.caddr_rd[L1_AW-1:0];

    async_ram #(.W(DW), .DEPTH(IMG_DEPTH)) u_img (
        .clk   (clk),
        .we    (img_we),
        .waddr (ld_cnt),
        .wdata (bus.s_data),
        .raddr (bus.iaddr),
        .rdata (bus.idata)
    );

    async_ram #(.W(DW), .DEPTH(IMG_DEPTH)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (bus.caddr_wr),
        .wdata (bus.cdata_wr),
        .raddr (l0_raddr),
        .rdata (l0_rd)
    );

    async_ram #(.W(DW), .DEPTH(L1_DEPTH)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (bus.caddr_wr[L1_AW-1:0]),
        .wdata (bus.cdata_wr),
        .raddr (l1_raddr),
        .rdata (l1_rd)
    );

    always_comb begin
        bus.cdata_rd = '0;
        case (bus.csel)
            CSEL_L0: bus.cdata_rd = l0_rd;
            CSEL_L1: bus.cdata_rd = l1_rd;
            default: bus.cdata_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = ST_LOAD;
            ST_LOAD:  if (bus.s_valid && (&ld_cnt)) state_nxt = ST_START;
            ST_START: if (bus.busy) state_nxt = ST_RUN;
            // busy_q is only ever high here after busy was seen high, so early lows cannot exit.
            ST_RUN:   if (busy_q && !bus.busy) state_nxt = ST_DUMP0;
            ST_DUMP0: begin
                issue = adv;
                if (adv && (&dp_cnt)) state_nxt = ST_DUMP1;
            end
            ST_DUMP1: begin
                if (adv) begin
                    if (dump_end) state_nxt = ST_DONE;
                    else          issue     = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_cnt      <= '0;
            dp_cnt      <= '0;
            busy_q      <= 1'b0;
            dump_end    <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
            bus.m_layer <= 1'b0;
        end else begin
            busy_q <= bus.busy;
            if (img_we) ld_cnt <= ld_cnt + 12'd1;
            if (issue) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= (state == ST_DUMP0) ? l0_rd : l1_rd;
                bus.m_layer <= (state == ST_DUMP1);
                // dp_cnt wraps 4095 -> 0 on the L0/L1 boundary, so L1 starts at 0 with no bubble.
                dp_cnt      <= dp_cnt + 12'd1;
                if (state == ST_DUMP0) begin
                    bus.m_last <= &dp_cnt;
                end else begin
                    bus.m_last <= &dp_cnt[L1_AW-1:0];
                    if (&dp_cnt[L1_AW-1:0]) dump_end <= 1'b1;
                end
            end else if (adv) begin
                bus.m_valid <= 1'b0;
            end
        end
    end

`ifdef ACCESS_CHECK_EN
    logic acc_bad;
    logic err_q;

    assign acc_bad = ((bus.cwr || bus.crd) && (bus.csel != CSEL_L0) && (bus.csel != CSEL_L1))
                   || (bus.cwr && (bus.csel == CSEL_L1) && (bus.caddr_wr[IMG_AW-1:L1_AW] != '0))
                   || (bus.cwr && (state != ST_RUN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else if (acc_bad) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    logic unused_crd;
    assign unused_crd = bus.crd;
    assign bus.err    = 1'b0;
`endif
endmodule
